aes_req_arbiter: RTL and testbench
==================================

# aes_req_arbiter

Round-robin arbiter that shares one masked AES encryption core (e.g. `aes_enc128_32bits_hpc2`) between `NREQ` independent requesters over valid/ready streams. Sits between the requesters and the core's plaintext/key input and ciphertext output. Records which requester owns each encryption in flight in a tag FIFO. Routes each ciphertext back to its owner, relying on the core returning results in input order. Adds no pipeline stage on data; all share buses pass through combinationally.

## Interface
- `d`, 2, number of shares
- `NREQ`, 2, number of requesters (≥2)
- `TAGDEPTH`, 4, maximum encryptions in flight (tag FIFO depth, ≥1)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  NREQ  per-requester input valid
- `req_ready`  out  NREQ  per-requester input ready
- `req_shares_plaintext`  in  NREQ*128*d  requester i at slice [i*128*d +: 128*d]
- `req_shares_key`  in  NREQ*128*d  same slicing
- `core_in_valid`  out  1  to core `in_valid`
- `core_in_ready`  in  1  from core `in_ready`
- `core_shares_plaintext`  out  128*d  granted requester's plaintext
- `core_shares_key`  out  128*d  granted requester's key
- `core_out_valid`  in  1  from core `out_valid`
- `core_out_ready`  out  1  to core `out_ready`
- `core_shares_ciphertext`  in  128*d  from core
- `rsp_valid`  out  NREQ  per-requester ciphertext valid
- `rsp_ready`  in  NREQ  per-requester ciphertext ready
- `rsp_shares_ciphertext`  out  128*d  `core_shares_ciphertext` broadcast to all
- `busy`  out  1  high when the tag FIFO is non-empty or a grant is locked
- `err`  out  1  sticky: core delivered output with the tag FIFO empty

## Operation
- State: `ptr` (priority pointer, clog2(NREQ) bits), `locked` and `lock_id`, tag FIFO (`TAGDEPTH` entries × clog2(NREQ) bits, head/tail wrap modulo `TAGDEPTH`), `count` (clog2(TAGDEPTH+1) bits), `err`.
- Grant FSM, two states:
  - IDLE (`locked`=0): grant `g` is the first i with `req_valid[i]`=1, scanning `ptr`, `ptr+1`, … modulo NREQ. No valid requester means no grant.
  - LOCKED (`locked`=1): `g` = `lock_id`, regardless of the other requesters.
- `core_in_valid` = grant exists & `req_valid[g]` & (`count` < `TAGDEPTH`). Core share buses carry slice `g`; they are zero when there is no grant.
- `req_ready[g]` = `core_in_ready` & `core_in_valid`. All other `req_ready` bits are 0.
- Input handshake (`core_in_valid` & `core_in_ready`):
  - push `g` into the FIFO;
  - `ptr` ← (g+1) mod NREQ;
  - `locked` ← 0.
- `core_in_valid` high without `core_in_ready`: `locked` ← 1, `lock_id` ← g. This keeps the offered data stable until accepted.
- In LOCKED, `req_valid[lock_id]` falling (protocol violation) → `locked` ← 0.
- FIFO full (`count`=`TAGDEPTH`) blocks the push even if a pop happens in the same cycle. A grant still locks while the FIFO is full.
- Output side with `h` = FIFO head and FIFO non-empty:
  - `rsp_valid[h]` = `core_out_valid`; all other bits are 0.
  - `core_out_ready` = `rsp_ready[h]`.
  - Handshake pops the head.
- Output side with FIFO empty: `rsp_valid` = 0 and `core_out_ready` = 0. If `core_out_valid`=1, `err` ← 1. `err` clears only on reset.
- A push and a pop in the same cycle leave `count` unchanged.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state: `ptr`=0, `locked`=0, FIFO empty, `count`=0, `err`=0;
  - outputs: `req_ready`=0, `core_in_valid`=0, `core_out_ready`=0, `rsp_valid`=0, `busy`=0.
- Reset mid-operation discards all tags; the core must be reset together with the arbiter.
- Zero-cycle latency requester→core and core→requester; the only paths are combinational.
- A request can be accepted in the same cycle it is raised. Back-to-back acceptances at one per cycle are possible whenever the core allows.
- `ptr`, `locked` and FIFO updates become visible the cycle after the handshake.
- The `busy` and `err` outputs are registered or derived from registers, with no combinational path from inputs.

## Test plan
- Single requester, NREQ=2: `req_valid`=01, core ready, one encryption → `core_in_valid` in the same cycle. FIFO holds tag 0. The ciphertext appears only on `rsp_valid`=01, and `busy` drops the cycle after the output handshake.
- Contention: `req_valid`=11 held for 4 acceptances from reset → grants 0,1,0,1. Tags are popped in the same order and responses go to 0,1,0,1.
- Backpressure lock: `ptr`=0 and only requester 1 valid, with `core_in_ready`=0 for 3 cycles. Requester 0 raises valid in cycle 2 → grant stays 1 and the core buses hold requester 1's data until `core_in_ready`=1.
- FIFO full, TAGDEPTH=2, core never outputs: two acceptances, then a third request → `core_in_valid`=0. After one output handshake → accepted on the following cycle.
- Output stall: head tag 1, `core_out_valid`=1, `rsp_ready`=01 → `core_out_ready`=0 and there is no pop. Setting `rsp_ready`=10 → pop; `count` decrements next cycle.
- Errors and reset: `core_out_valid`=1 with the FIFO empty → `err`=1 the next cycle. Asserting `rst` mid-burst → all outputs 0 immediately and `err`=0.

Source files
------------

// File: rtl/aes_req_arbiter.sv
// Round-robin arbiter sharing one masked AES core between NREQ valid/ready requesters.
// A tag FIFO records the owner of each in-flight encryption so results route back in order.
module aes_req_arbiter #(
  parameter int d        = 2,
  parameter int NREQ     = 2,
  parameter int TAGDEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*128*d-1:0] req_shares_plaintext,
  input  logic [NREQ*128*d-1:0] req_shares_key,
  output logic                  core_in_valid,
  input  logic                  core_in_ready,
  output logic [128*d-1:0]      core_shares_plaintext,
  output logic [128*d-1:0]      core_shares_key,
  input  logic                  core_out_valid,
  output logic                  core_out_ready,
  input  logic [128*d-1:0]      core_shares_ciphertext,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [128*d-1:0]      rsp_shares_ciphertext,
  output logic                  busy,
  output logic                  err
);

  localparam int SW  = 128 * d;
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = $clog2(TAGDEPTH + 1);
  localparam int AW  = (TAGDEPTH > 1) ? $clog2(TAGDEPTH) : 1;

  typedef logic [IDW-1:0] id_t;
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state, state_nxt;
  id_t           lock_id, lock_id_nxt;
  id_t           ptr;
  id_t           g, cand, head_id;
  logic          grant_vld;
  logic          fifo_full, fifo_empty;
  logic          hs_in, hs_out;
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  id_t           tag_mem [TAGDEPTH];

  // Round-robin scan runs high to low so the lowest offset from ptr wins.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    grant_vld = 1'b0;
    g         = '0;
    cand      = '0;
    if (state == LOCKED) begin
      grant_vld = 1'b1;
      g         = lock_id;
    end else begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        cand = id_t'((int'(ptr) + k) % NREQ);
        if (req_valid[cand]) begin
          grant_vld = 1'b1;
          g         = cand;
        end
      end
    end
  end

  assign fifo_full  = (count == CW'(TAGDEPTH));
  assign fifo_empty = (count == '0);
  assign head_id    = tag_mem[head];

  // Reset gates the only output that could otherwise follow req_valid during reset.
  assign core_in_valid = !rst && grant_vld && req_valid[g] && !fifo_full;
  assign hs_in         = core_in_valid && core_in_ready;
  assign req_ready     = hs_in ? (NREQ'(1) << g) : '0;

  assign core_shares_plaintext = grant_vld ? req_shares_plaintext[int'(g)*SW +: SW] : '0;
  assign core_shares_key       = grant_vld ? req_shares_key[int'(g)*SW +: SW] : '0;

  assign rsp_valid             = (!fifo_empty && core_out_valid) ? (NREQ'(1) << head_id) : '0;
  assign core_out_ready        = !fifo_empty && rsp_ready[head_id];
  assign hs_out                = core_out_valid && core_out_ready;
  assign rsp_shares_ciphertext = core_shares_ciphertext;

  assign busy = (count != '0) || (state == LOCKED);

  // Lock holds the grant while the core stalls; a dropped request releases it.
  always_comb begin
    state_nxt   = state;
    lock_id_nxt = lock_id;
    if (hs_in) begin
      state_nxt = IDLE;
    end else if (grant_vld && req_valid[g]) begin
      state_nxt   = LOCKED;
      lock_id_nxt = g;
    end else begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lock_id <= '0;
      ptr     <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      err     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state   <= state_nxt;
      lock_id <= lock_id_nxt;
      if (hs_in) begin
        ptr  <= (g == id_t'(NREQ - 1)) ? '0 : g + id_t'(1);
        tail <= (tail == AW'(TAGDEPTH - 1)) ? '0 : tail + AW'(1);
      end
      if (hs_out) head <= (head == AW'(TAGDEPTH - 1)) ? '0 : head + AW'(1);
      case ({hs_in, hs_out})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (fifo_empty && core_out_valid) err <= 1'b1;
    end
  end

  // NOTE: tag storage has no reset; head/tail/count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (hs_in) tag_mem[tail] <= g;
  end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Self-checking bench for aes_req_arbiter: queue-based reference model compared every
// falling edge, plus directed scenarios with literal expectations.
module tb_aes_req_arbiter;

  localparam int D        = 2;
  localparam int NREQ     = 2;
  localparam int TAGDEPTH = 2;
  localparam int SW       = 128 * D;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*SW-1:0]   req_shares_plaintext;
  logic [NREQ*SW-1:0]   req_shares_key;
  logic                 core_in_valid;
  logic                 core_in_ready;
  logic [SW-1:0]        core_shares_plaintext;
  logic [SW-1:0]        core_shares_key;
  logic                 core_out_valid;
  logic                 core_out_ready;
  logic [SW-1:0]        core_shares_ciphertext;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [SW-1:0]        rsp_shares_ciphertext;
  logic                 busy;
  logic                 err;

  aes_req_arbiter #(.d(D), .NREQ(NREQ), .TAGDEPTH(TAGDEPTH)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .req_valid              (req_valid),
    .req_ready              (req_ready),
    .req_shares_plaintext   (req_shares_plaintext),
    .req_shares_key         (req_shares_key),
    .core_in_valid          (core_in_valid),
    .core_in_ready          (core_in_ready),
    .core_shares_plaintext  (core_shares_plaintext),
    .core_shares_key        (core_shares_key),
    .core_out_valid         (core_out_valid),
    .core_out_ready         (core_out_ready),
    .core_shares_ciphertext (core_shares_ciphertext),
    .rsp_valid              (rsp_valid),
    .rsp_ready              (rsp_ready),
    .rsp_shares_ciphertext  (rsp_shares_ciphertext),
    .busy                   (busy),
    .err                    (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] pt(input int i);
    logic [31:0] w;
    w = 32'hA0A0_0000 + 32'(i);
    return {8{w}};
  endfunction

  function automatic logic [SW-1:0] key(input int i);
    logic [31:0] w;
    w = 32'h5EED_1000 + 32'(i);
    return {8{w}};
  endfunction

  function automatic logic [SW-1:0] ct(input int i);
    logic [31:0] w;
    w = 32'hC1C1_0000 + 32'(i);
    return {8{w}};
  endfunction

  // Reference model: owners of in-flight encryptions as a plain queue.
  int  m_tags[$];
  int  m_ptr     = 0;
  bit  m_locked  = 0;
  int  m_lock_id = 0;
  bit  m_err     = 0;

  int            e_g;
  bit            e_has;
  bit            e_civ, e_hs_in, e_hs_out, e_cor;
  logic [NREQ-1:0] e_rr, e_rv;

  always @(negedge clk) begin
    if (rst) begin
      check("rst req_ready", SW'(req_ready), '0);
      check("rst core_in_valid", SW'(core_in_valid), '0);
      check("rst core_out_ready", SW'(core_out_ready), '0);
      check("rst rsp_valid", SW'(rsp_valid), '0);
      check("rst busy", SW'(busy), '0);
      check("rst err", SW'(err), '0);
      m_tags.delete();
      m_ptr = 0; m_locked = 0; m_lock_id = 0; m_err = 0;
    end else begin
      e_has = 0;
      e_g   = 0;
      if (m_locked) begin
        e_has = 1;
        e_g   = m_lock_id;
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          if (!e_has && req_valid[(m_ptr + k) % NREQ]) begin
            e_has = 1;
            e_g   = (m_ptr + k) % NREQ;
          end
        end
      end
      e_civ   = e_has && req_valid[e_g] && (m_tags.size() < TAGDEPTH);
      e_hs_in = e_civ && core_in_ready;
      e_rr    = '0;
      if (e_hs_in) e_rr[e_g] = 1'b1;
      e_rv  = '0;
      e_cor = 0;
      if (m_tags.size() > 0) begin
        e_rv[m_tags[0]] = core_out_valid;
        e_cor           = rsp_ready[m_tags[0]];
      end
      e_hs_out = core_out_valid && e_cor;

      check("core_in_valid", SW'(core_in_valid), SW'(e_civ));
      check("req_ready", SW'(req_ready), SW'(e_rr));
      check("core_plaintext", core_shares_plaintext, e_has ? pt(e_g) : '0);
      check("core_key", core_shares_key, e_has ? key(e_g) : '0);
      check("rsp_valid", SW'(rsp_valid), SW'(e_rv));
      check("core_out_ready", SW'(core_out_ready), SW'(e_cor));
      check("rsp_ciphertext", rsp_shares_ciphertext, core_shares_ciphertext);
      check("busy", SW'(busy), SW'(m_tags.size() > 0 || m_locked));
      check("err", SW'(err), SW'(m_err));

      if (m_tags.size() == 0 && core_out_valid) m_err = 1;
      if (e_hs_out) void'(m_tags.pop_front());
      if (e_hs_in) begin
        m_tags.push_back(e_g);
        m_ptr    = (e_g + 1) % NREQ;
        m_locked = 0;
      end else if (e_has && req_valid[e_g]) begin
        m_locked  = 1;
        m_lock_id = e_g;
      end else begin
        m_locked = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int grants[$];
  int rsps[$];
  int exp_seq[4] = '{0, 1, 0, 1};

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      req_shares_plaintext[i*SW +: SW] = pt(i);
      req_shares_key[i*SW +: SW]       = key(i);
    end
    rst = 1; req_valid = '0; core_in_ready = 0; core_out_valid = 0;
    rsp_ready = '0; core_shares_ciphertext = '0;
    step(); step();
    rst = 0;

    // Single requester: accepted in the same cycle, response only to requester 0.
    req_valid = 2'b01; core_in_ready = 1;
    #1;
    check("t1 civ same cycle", SW'(core_in_valid), SW'(1'b1));
    check("t1 req_ready", SW'(req_ready), SW'(2'b01));
    check("t1 plaintext", core_shares_plaintext, pt(0));
    step();
    req_valid = '0; core_out_valid = 1; rsp_ready = 2'b01; core_shares_ciphertext = ct(9);
    #1;
    check("t1 busy in flight", SW'(busy), SW'(1'b1));
    check("t1 rsp_valid", SW'(rsp_valid), SW'(2'b01));
    check("t1 rsp data", rsp_shares_ciphertext, ct(9));
    step();
    core_out_valid = 0; rsp_ready = '0;
    #1;
    check("t1 busy dropped", SW'(busy), SW'(1'b0));

    // Contention from reset: grants and responses alternate 0,1,0,1.
    rst = 1; step(); rst = 0;
    req_valid = 2'b11; core_in_ready = 1; rsp_ready = 2'b11;
    for (int cyc = 0; cyc < 40 && (grants.size() < 4 || rsps.size() < 4); cyc++) begin
      if (grants.size() >= 4) req_valid = '0;
      core_out_valid         = (m_tags.size() > 0);
      core_shares_ciphertext = ct(rsps.size());
      #1;
      if (core_in_valid && core_in_ready) grants.push_back(req_ready[1] ? 1 : 0);
      if (core_out_valid && core_out_ready) begin
        check("t2 rsp data", rsp_shares_ciphertext, ct(rsps.size()));
        rsps.push_back(rsp_valid[1] ? 1 : 0);
      end
      step();
    end
    req_valid = '0; core_out_valid = 0; rsp_ready = '0;
    check("t2 grant count", SW'(grants.size()), SW'(4));
    check("t2 rsp count", SW'(rsps.size()), SW'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < grants.size()) check("t2 grant order", SW'(grants[i]), SW'(exp_seq[i]));
      if (i < rsps.size())   check("t2 rsp order", SW'(rsps[i]), SW'(exp_seq[i]));
    end
    step();

    // Backpressure lock: ptr=0, requester 1 locked while requester 0 joins.
    core_in_ready = 0; req_valid = 2'b10;
    #1;
    check("t3 civ", SW'(core_in_valid), SW'(1'b1));
    check("t3 pt c1", core_shares_plaintext, pt(1));
    step();
    req_valid = 2'b11;
    #1;
    check("t3 pt c2", core_shares_plaintext, pt(1));
    check("t3 key c2", core_shares_key, key(1));
    check("t3 no ready", SW'(req_ready), SW'(2'b00));
    step();
    check("t3 pt c3", core_shares_plaintext, pt(1));
    step();
    core_in_ready = 1;
    #1;
    check("t3 ready to 1", SW'(req_ready), SW'(2'b10));
    step();
    req_valid = '0; core_out_valid = 1; rsp_ready = 2'b10;
    #1;
    check("t3 rsp to 1", SW'(rsp_valid), SW'(2'b10));
    step();
    core_out_valid = 0; rsp_ready = '0;

    // FIFO full blocks a third push, even alongside a pop.
    req_valid = 2'b01;
    #1;
    check("t4 push1", SW'(core_in_valid), SW'(1'b1));
    step();
    check("t4 push2", SW'(core_in_valid), SW'(1'b1));
    step();
    check("t4 full blocks", SW'(core_in_valid), SW'(1'b0));
    core_out_valid = 1; rsp_ready = 2'b01;
    #1;
    check("t4 full with pop", SW'(core_in_valid), SW'(1'b0));
    check("t4 pop ready", SW'(core_out_ready), SW'(1'b1));
    step();
    core_out_valid = 0;
    #1;
    check("t4 accept after pop", SW'(core_in_valid), SW'(1'b1));
    step();
    req_valid = '0; core_out_valid = 1;
    step(); step();
    core_out_valid = 0; rsp_ready = '0;

    // Output stall: head tag 1, wrong requester ready.
    req_valid = 2'b10;
    step();
    req_valid = '0; core_out_valid = 1; rsp_ready = 2'b01;
    #1;
    check("t5 stall ready", SW'(core_out_ready), SW'(1'b0));
    check("t5 stall rsp_valid", SW'(rsp_valid), SW'(2'b10));
    step();
    check("t5 no pop busy", SW'(busy), SW'(1'b1));
    rsp_ready = 2'b10;
    #1;
    check("t5 ready", SW'(core_out_ready), SW'(1'b1));
    step();
    core_out_valid = 0; rsp_ready = '0;
    #1;
    check("t5 popped", SW'(busy), SW'(1'b0));

    // Spurious output with empty FIFO, then reset mid-burst.
    core_out_valid = 1;
    #1;
    check("t6 err not yet", SW'(err), SW'(1'b0));
    step();
    core_out_valid = 0;
    #1;
    check("t6 err set", SW'(err), SW'(1'b1));
    req_valid = 2'b11; core_in_ready = 1;
    step(); step();
    #1;
    rst = 1;
    #1;
    check("t6 rst civ", SW'(core_in_valid), SW'(1'b0));
    check("t6 rst req_ready", SW'(req_ready), SW'(2'b00));
    check("t6 rst busy", SW'(busy), SW'(1'b0));
    check("t6 rst err", SW'(err), SW'(1'b0));
    step(); step();
    rst = 0; req_valid = '0; core_in_ready = 0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
